// File: rtl/dcache_warmup_loader_if.sv
// Checkpoint beat stream plus the tag/data SRAM RW0 write ports driven by the
// dcache warmup loader. The loader uses the master modport.
interface dcache_warmup_loader_if #(
    parameter int SETS     = 64,
    parameter int WAYS     = 4,
    parameter int ROWS     = 8,
    parameter int TAG_BITS = 22,
    parameter int ROW_BITS = 64
);
    localparam int SET_W   = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int DADDR_W = (SETS * ROWS > 1) ? $clog2(SETS * ROWS) : 1;
    localparam int DMASK_W = WAYS * ROW_BITS / 8;

    logic                       in_valid;
    logic                       in_ready;
    logic [ROW_BITS-1:0]        in_data;

    logic [SET_W-1:0]           tag_addr;
    logic                       tag_en;
    logic                       tag_wmode;
    logic [TAG_BITS*WAYS-1:0]   tag_wdata;
    logic [WAYS-1:0]            tag_wmask;

    logic [DADDR_W-1:0]         data_addr;
    logic                       data_en;
    logic                       data_wmode;
    logic [ROW_BITS*WAYS-1:0]   data_wdata;
    logic [DMASK_W-1:0]         data_wmask;

    modport master (
        input  in_valid, in_data,
        output in_ready,
        output tag_addr, tag_en, tag_wmode, tag_wdata, tag_wmask,
        output data_addr, data_en, data_wmode, data_wdata, data_wmask
    );

    modport slave (
        output in_valid, in_data,
        input  in_ready,
        input  tag_addr, tag_en, tag_wmode, tag_wdata, tag_wmask,
        input  data_addr, data_en, data_wmode, data_wdata, data_wmask
    );
endinterface

// File: rtl/dcache_warmup_loader.sv
// Streams a checkpoint image into the dcache tag and data SRAMs while holding
// the core in reset; releases the core once every tag and data row is written.
module dcache_warmup_loader #(
    parameter int SETS     = 64,
    parameter int WAYS     = 4,
    parameter int ROWS     = 8,
    parameter int TAG_BITS = 22,
    parameter int ROW_BITS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    dcache_warmup_loader_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   core_hold,
    output logic [11:0]            beat_count
);
    localparam int SET_W   = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DADDR_W = (SETS * ROWS > 1) ? $clog2(SETS * ROWS) : 1;
    localparam int BYTES   = ROW_BITS / 8;
    localparam int DMASK_W = WAYS * BYTES;

    typedef enum logic [1:0] {IDLE, TAG, DATA, DONE} state_t;

    state_t             state, state_next;
    logic [SET_W-1:0]   set_idx;
    logic [WAY_W-1:0]   way_idx;
    logic [ROW_W-1:0]   row_idx;
    logic               beat;
    logic               last_way, last_row, last_set;

    assign last_way = (way_idx == WAY_W'(WAYS - 1));
    assign last_row = (row_idx == ROW_W'(ROWS - 1));
    assign last_set = (set_idx == SET_W'(SETS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            set_idx    <= '0;
            way_idx    <= '0;
            row_idx    <= '0;
            beat_count <= '0;
        end else begin
            state <= state_next;
            if (beat) begin
                if (beat_count != 12'hFFF)
                    beat_count <= beat_count + 12'd1;
                way_idx <= last_way ? '0 : way_idx + WAY_W'(1);
                // Rows only exist in the data phase; the tag phase steps set directly.
                if (last_way) begin
                    if (state == DATA && !last_row) begin
                        row_idx <= row_idx + ROW_W'(1);
                    end else begin
                        row_idx <= '0;
                        set_idx <= last_set ? '0 : set_idx + SET_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        state_next     = state;
        beat           = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        core_hold      = 1'b1;
        bus.in_ready   = 1'b0;
        bus.tag_addr   = '0;
        bus.tag_en     = 1'b0;
        bus.tag_wmode  = 1'b0;
        bus.tag_wdata  = '0;
        bus.tag_wmask  = '0;
        bus.data_addr  = '0;
        bus.data_en    = 1'b0;
        bus.data_wmode = 1'b0;
        bus.data_wdata = '0;
        bus.data_wmask = '0;

        case (state)
            IDLE: begin
                if (start)
                    state_next = TAG;
            end
            TAG: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                beat         = bus.in_valid;
                if (beat) begin
                    bus.tag_en    = 1'b1;
                    bus.tag_wmode = 1'b1;
                    bus.tag_addr  = set_idx;
                    bus.tag_wdata = {WAYS{bus.in_data[TAG_BITS-1:0]}};
                    bus.tag_wmask = WAYS'(1) << way_idx;
                    if (last_way && last_set)
                        state_next = DATA;
                end
            end
            DATA: begin
                bus.in_ready = 1'b1;
                busy         = 1'b1;
                beat         = bus.in_valid;
                if (beat) begin
                    bus.data_en    = 1'b1;
                    bus.data_wmode = 1'b1;
                    bus.data_addr  = DADDR_W'(set_idx) * DADDR_W'(ROWS) + DADDR_W'(row_idx);
                    bus.data_wdata = {WAYS{bus.in_data}};
                    bus.data_wmask = DMASK_W'({BYTES{1'b1}}) << (way_idx * BYTES);
                    if (last_way && last_row && last_set)
                        state_next = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                core_hold = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dcache_warmup_loader.sv
// Randomized bench for dcache_warmup_loader: expected SRAM writes are derived
// from the beat index alone (way fastest, then row, then set).
module tb_dcache_warmup_loader;
    localparam int SETS       = 64;
    localparam int WAYS       = 4;
    localparam int ROWS       = 8;
    localparam int TAG_BITS   = 22;
    localparam int ROW_BITS   = 64;
    localparam int TAG_BEATS  = SETS * WAYS;
    localparam int DATA_BEATS = SETS * ROWS * WAYS;
    localparam int TOTAL      = TAG_BEATS + DATA_BEATS;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, core_hold;
    logic [11:0] beat_count;

    int n_checks = 0;
    int n_fail = 0;
    int model_beats = 0;
    int tag_writes = 0;
    int data_writes = 0;

    dcache_warmup_loader_if #(
        .SETS(SETS), .WAYS(WAYS), .ROWS(ROWS), .TAG_BITS(TAG_BITS), .ROW_BITS(ROW_BITS)
    ) bus ();

    dcache_warmup_loader #(
        .SETS(SETS), .WAYS(WAYS), .ROWS(ROWS), .TAG_BITS(TAG_BITS), .ROW_BITS(ROW_BITS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus),
        .busy(busy),
        .done(done),
        .core_hold(core_hold),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_beats = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = {$urandom, $urandom};
            #1;
            n_checks++;
            if ({bus.in_ready, core_hold, busy, done, bus.tag_en, bus.data_en} !== 6'b010000) begin
                n_fail++;
                $display("[TB] FAIL idle_status cycle %0d: got %b expected 010000", c,
                         {bus.in_ready, core_hold, busy, done, bus.tag_en, bus.data_en});
            end
            n_checks++;
            if (beat_count !== 12'd0) begin
                n_fail++;
                $display("[TB] FAIL idle_beat_count: got %0d expected 0", beat_count);
            end
            n_checks++;
            if ({bus.tag_addr, bus.tag_wdata, bus.tag_wmask, bus.tag_wmode,
                 bus.data_addr, bus.data_wdata, bus.data_wmask, bus.data_wmode} !== '0) begin
                n_fail++;
                $display("[TB] FAIL idle_sram_zero cycle %0d: SRAM outputs not zero", c);
            end
        end
    endtask

    // Drives n beats (optionally with random in_valid gaps) and checks every cycle.
    task automatic stream_beats(input int n, input bit gaps);
        int          sent = 0;
        int          cycles = 0;
        int          k, d, s, w, r;
        logic [99:0] exp_tag, obs_tag;
        logic [298:0] exp_dat, obs_dat;
        while (sent < n && cycles < 8000) begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
            bus.in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.in_data = {$urandom, $urandom};
            if (model_beats == 0)
                bus.in_data[21:0] = 22'h2AAAAA;
            #1;
            k = model_beats;
            exp_tag = '0;
            exp_dat = '0;
            if (bus.in_valid) begin
                if (k < TAG_BEATS) begin
                    s = k / WAYS;
                    w = k % WAYS;
                    exp_tag = {1'b1, 1'b1, 6'(s), {WAYS{bus.in_data[TAG_BITS-1:0]}}, 4'(1 << w)};
                end else begin
                    d = k - TAG_BEATS;
                    w = d % WAYS;
                    r = (d / WAYS) % ROWS;
                    s = d / (WAYS * ROWS);
                    exp_dat = {1'b1, 1'b1, 9'(s * ROWS + r), {WAYS{bus.in_data}},
                               32'(64'hFF << (w * 8))};
                end
            end
            obs_tag = {bus.tag_en, bus.tag_wmode, bus.tag_addr, bus.tag_wdata, bus.tag_wmask};
            obs_dat = {bus.data_en, bus.data_wmode, bus.data_addr, bus.data_wdata, bus.data_wmask};
            n_checks++;
            if (obs_tag !== exp_tag) begin
                n_fail++;
                $display("[TB] FAIL tag_port beat %0d: got %h expected %h", k, obs_tag, exp_tag);
            end
            n_checks++;
            if (obs_dat !== exp_dat) begin
                n_fail++;
                $display("[TB] FAIL data_port beat %0d: got %h expected %h", k, obs_dat, exp_dat);
            end
            n_checks++;
            if ({bus.in_ready, busy, core_hold, done} !== 4'b1110) begin
                n_fail++;
                $display("[TB] FAIL load_status beat %0d: got %b expected 1110", k,
                         {bus.in_ready, busy, core_hold, done});
            end
            n_checks++;
            if (beat_count !== 12'(k)) begin
                n_fail++;
                $display("[TB] FAIL beat_count: got %0d expected %0d", beat_count, k);
            end
            if (bus.in_valid && k == 0) begin
                n_checks++;
                if ({bus.tag_addr, bus.tag_wmask, bus.tag_wdata[21:0]} !== {6'd0, 4'b0001, 22'h2AAAAA}) begin
                    n_fail++;
                    $display("[TB] FAIL first_tag_beat: got %h expected %h",
                             {bus.tag_addr, bus.tag_wmask, bus.tag_wdata[21:0]},
                             {6'd0, 4'b0001, 22'h2AAAAA});
                end
            end
            if (bus.in_valid && k == 6) begin
                n_checks++;
                if ({bus.tag_addr, bus.tag_wmask} !== {6'd1, 4'b0100}) begin
                    n_fail++;
                    $display("[TB] FAIL tag_beat6: got %h expected %h",
                             {bus.tag_addr, bus.tag_wmask}, {6'd1, 4'b0100});
                end
            end
            if (bus.in_valid && k == TAG_BEATS + 37) begin
                n_checks++;
                if ({bus.data_addr, bus.data_wmask} !== {9'd9, 32'h0000FF00}) begin
                    n_fail++;
                    $display("[TB] FAIL data_beat37: got %h expected %h",
                             {bus.data_addr, bus.data_wmask}, {9'd9, 32'h0000FF00});
                end
            end
            tag_writes += int'(bus.tag_en);
            data_writes += int'(bus.data_en);
            if (bus.in_valid) begin
                model_beats++;
                sent++;
            end
        end
        if (sent < n) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL stream_timeout: got %0d beats expected %0d", sent, n);
        end
    endtask

    task automatic test_full_load();
        tag_writes = 0;
        data_writes = 0;
        @(negedge clk);
        start = 1'b1;
        bus.in_valid = 1'b1;
        #1;
        n_checks++;
        if ({bus.tag_en, bus.data_en, bus.in_ready} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL idle_no_write: got %b expected 000",
                     {bus.tag_en, bus.data_en, bus.in_ready});
        end
        stream_beats(TOTAL, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({done, core_hold, busy, bus.in_ready} !== 4'b1000) begin
            n_fail++;
            $display("[TB] FAIL done_status: got %b expected 1000",
                     {done, core_hold, busy, bus.in_ready});
        end
        n_checks++;
        if (beat_count !== 12'(TOTAL)) begin
            n_fail++;
            $display("[TB] FAIL final_beat_count: got %0d expected %0d", beat_count, TOTAL);
        end
        n_checks++;
        if (tag_writes != TAG_BEATS || data_writes != DATA_BEATS) begin
            n_fail++;
            $display("[TB] FAIL write_counts: got %0d/%0d expected %0d/%0d",
                     tag_writes, data_writes, TAG_BEATS, DATA_BEATS);
        end
    endtask

    task automatic test_start_in_done();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = (c == 0);
            bus.in_valid = 1'b1;
            bus.in_data = {$urandom, $urandom};
            #1;
            n_checks++;
            if ({done, core_hold, bus.in_ready, bus.tag_en, bus.data_en} !== 5'b10000) begin
                n_fail++;
                $display("[TB] FAIL done_hold cycle %0d: got %b expected 10000", c,
                         {done, core_hold, bus.in_ready, bus.tag_en, bus.data_en});
            end
            n_checks++;
            if (beat_count !== 12'(TOTAL)) begin
                n_fail++;
                $display("[TB] FAIL done_beat_count: got %0d expected %0d", beat_count, TOTAL);
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_data();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_beats = 0;
        start = 1'b1;
        stream_beats(1000, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, bus.in_ready, core_hold} !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_status: got %b expected 0001",
                     {busy, done, bus.in_ready, core_hold});
        end
        n_checks++;
        if (beat_count !== 12'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_beat_count: got %0d expected 0", beat_count);
        end
        model_beats = 0;
        start = 1'b1;
        stream_beats(8, 1'b1);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        test_reset();
        test_full_load();
        test_start_in_done();
        test_reset_mid_data();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
